// File: rtl/nco_pkg.sv
// Shared constants, LFSR step and quarter-wave table generator for the multi-channel NCO.
// The optional quadrature output is enabled by defining NCO_QUAD_OUT_EN.
package nco_pkg;

    typedef enum logic {
        CFG_SEL_FREQ  = 1'b0,
        CFG_SEL_PHASE = 1'b1
    } cfg_sel_e;

    localparam int          NCO_LATENCY = 4;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    // Feedback taps for x^16+x^14+x^13+x^11+1 in a right-shifting register
    localparam logic [15:0] LFSR_TAPS   = 16'h002D;
    localparam real         NCO_PI      = 3.14159265358979323846;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {^(state & LFSR_TAPS), state[15:1]};
    endfunction

    // Half-step sample offset keeps the quarter table symmetric under mirroring
    function automatic int quarter_sine(input int idx, input int quarter_bits, input int lut_width);
        real angle;
        real amp;
        angle = 2.0 * NCO_PI * (real'(idx) + 0.5) / (2.0 ** (quarter_bits + 2));
        amp   = (2.0 ** (lut_width - 1)) - 1.0;
        return $rtoi(amp * $sin(angle) + 0.5);
    endfunction

endpackage

// File: rtl/nco_quarter_rom.sv
// Synchronous quarter-wave sine ROM; a second read port exists when NCO_QUAD_OUT_EN is defined.
module nco_quarter_rom
    import nco_pkg::*;
#(
    parameter int ABITS  = 8,
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ABITS-1:0]  addr_a,
    output logic [DWIDTH-1:0] data_a
`ifdef NCO_QUAD_OUT_EN
    ,
    input  logic [ABITS-1:0]  addr_b,
    output logic [DWIDTH-1:0] data_b
`endif
);

    logic [DWIDTH-1:0] table_w [2**ABITS];
    logic [DWIDTH-1:0] data_a_d, data_a_q;

    for (genvar i = 0; i < 2**ABITS; i++) begin : g_tbl
        localparam int VALUE = quarter_sine(i, ABITS, DWIDTH);
        assign table_w[i] = DWIDTH'(VALUE);
    end

    always_comb begin
        data_a_d = table_w[addr_a];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_a_q <= '0;
        else        data_a_q <= data_a_d;
    end

    assign data_a = data_a_q;

`ifdef NCO_QUAD_OUT_EN
    logic [DWIDTH-1:0] data_b_d, data_b_q;

    always_comb begin
        data_b_d = table_w[addr_b];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_b_q <= '0;
        else        data_b_q <= data_b_d;
    end

    assign data_b = data_b_q;
`endif

endmodule

// File: rtl/nco_mc_quarter.sv
// Round-robin multi-channel NCO with quarter-wave ROM, LFSR dither and sweep-aligned config update.
// Define NCO_QUAD_OUT_EN to add the out_cos quadrature output.
module nco_mc_quarter
    import nco_pkg::*;
#(
    parameter  int NUM_CH       = 4,
    parameter  int ACC_WIDTH    = 24,
    parameter  int ADDR_WIDTH   = 10,
    parameter  int LUT_WIDTH    = 16,
    parameter  int DITHER_WIDTH = 3,
    localparam int CH_W         = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_we,
    input  logic                 cfg_sel,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [ACC_WIDTH-1:0] cfg_data,
    input  logic                 update,
    output logic                 out_valid,
    output logic [CH_W-1:0]      out_ch,
    output logic [LUT_WIDTH-1:0] out_sin
`ifdef NCO_QUAD_OUT_EN
    ,
    output logic [LUT_WIDTH-1:0] out_cos
`endif
);

    localparam int QBITS = ADDR_WIDTH - 2;

    logic [CH_W-1:0]      ch_cnt_d, ch_cnt_q;
    logic [ACC_WIDTH-1:0] acc_d [NUM_CH];
    logic [ACC_WIDTH-1:0] acc_q [NUM_CH];
    logic [ACC_WIDTH-1:0] freq_sh_d [NUM_CH];
    logic [ACC_WIDTH-1:0] freq_sh_q [NUM_CH];
    logic [ACC_WIDTH-1:0] phase_sh_d [NUM_CH];
    logic [ACC_WIDTH-1:0] phase_sh_q [NUM_CH];
    logic [ACC_WIDTH-1:0] freq_act_d [NUM_CH];
    logic [ACC_WIDTH-1:0] freq_act_q [NUM_CH];
    logic [ACC_WIDTH-1:0] phase_act_d [NUM_CH];
    logic [ACC_WIDTH-1:0] phase_act_q [NUM_CH];
    logic                 pend_d, pend_q;
    logic [15:0]          lfsr_d, lfsr_q;
    logic [ACC_WIDTH-1:0] phase_sum;
    logic                 last_slot;
    logic                 apply;

    logic [ADDR_WIDTH-1:0] dith_next;
    logic                  v0_d, v0_q, v1_d, v1_q, v2_d, v2_q;
    logic [CH_W-1:0]       ch0_d, ch0_q, ch1_d, ch1_q, ch2_d, ch2_q;
    logic [ADDR_WIDTH-1:0] ph0_d, ph0_q, dith0_d, dith0_q, idx1;
    logic [1:0]            quad1_d, quad1_q, quadc;
    logic [QBITS-1:0]      fine1_d, fine1_q, finec1_d, finec1_q;
    logic [1:0]            quadc1_d, quadc1_q;
    logic                  neg2_d, neg2_q, negc2_d, negc2_q;
    logic                  out_valid_d, out_valid_q;
    logic [CH_W-1:0]       out_ch_d, out_ch_q;
    logic [LUT_WIDTH-1:0]  out_sin_d, out_sin_q, out_cos_d, out_cos_q;
    logic [LUT_WIDTH-1:0]  rom_sin_raw, rom_cos_raw;

    if (DITHER_WIDTH > 0) begin : g_dither
        assign dith_next = ADDR_WIDTH'(lfsr_q[DITHER_WIDTH-1:0]);
    end else begin : g_no_dither
        assign dith_next = '0;
    end

    // Slot issue, accumulator advance and sweep-aligned shadow-to-active transfer
    always_comb begin
        ch_cnt_d    = ch_cnt_q;
        acc_d       = acc_q;
        freq_sh_d   = freq_sh_q;
        phase_sh_d  = phase_sh_q;
        freq_act_d  = freq_act_q;
        phase_act_d = phase_act_q;
        lfsr_d      = lfsr_q;
        last_slot   = (ch_cnt_q == CH_W'(NUM_CH - 1));
        phase_sum   = acc_q[ch_cnt_q] + phase_act_q[ch_cnt_q];
        if (en) begin
            acc_d[ch_cnt_q] = acc_q[ch_cnt_q] + freq_act_q[ch_cnt_q];
            ch_cnt_d        = last_slot ? '0 : ch_cnt_q + 1'b1;
            lfsr_d          = lfsr_next(lfsr_q);
        end
        apply = (pend_q | update) & (~en | last_slot);
        if (apply) begin
            freq_act_d  = freq_sh_q;
            phase_act_d = phase_sh_q;
            pend_d      = 1'b0;
        end else begin
            pend_d      = pend_q | update;
        end
        if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
            if (cfg_sel == CFG_SEL_PHASE) phase_sh_d[cfg_ch] = cfg_data;
            else                          freq_sh_d[cfg_ch]  = cfg_data;
        end
    end

    always_comb begin
        v0_d     = en;
        ch0_d    = ch_cnt_q;
        ph0_d    = phase_sum[ACC_WIDTH-1 -: ADDR_WIDTH];
        dith0_d  = dith_next;
        idx1     = ph0_q + dith0_q;
        v1_d     = v0_q;
        ch1_d    = ch0_q;
        quad1_d  = idx1[ADDR_WIDTH-1 -: 2];
        fine1_d  = idx1[ADDR_WIDTH-2] ? ~idx1[QBITS-1:0] : idx1[QBITS-1:0];
        // Quadrature sample sits one quadrant ahead and shares the fine index bits
        quadc    = quad1_d + 2'd1;
        quadc1_d = quadc;
        finec1_d = quadc[0] ? ~idx1[QBITS-1:0] : idx1[QBITS-1:0];
        v2_d     = v1_q;
        ch2_d    = ch1_q;
        neg2_d   = quad1_q[1];
        negc2_d  = quadc1_q[1];
        out_valid_d = v2_q;
        out_ch_d    = ch2_q;
        out_sin_d   = neg2_q  ? -rom_sin_raw : rom_sin_raw;
        out_cos_d   = negc2_q ? -rom_cos_raw : rom_cos_raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]       <= '0;
                freq_sh_q[i]   <= '0;
                phase_sh_q[i]  <= '0;
                freq_act_q[i]  <= '0;
                phase_act_q[i] <= '0;
            end
            pend_q      <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            v0_q        <= 1'b0;
            ch0_q       <= '0;
            ph0_q       <= '0;
            dith0_q     <= '0;
            v1_q        <= 1'b0;
            ch1_q       <= '0;
            quad1_q     <= '0;
            fine1_q     <= '0;
            quadc1_q    <= '0;
            finec1_q    <= '0;
            v2_q        <= 1'b0;
            ch2_q       <= '0;
            neg2_q      <= 1'b0;
            negc2_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_sin_q   <= '0;
            out_cos_q   <= '0;
        end else begin
            ch_cnt_q    <= ch_cnt_d;
            acc_q       <= acc_d;
            freq_sh_q   <= freq_sh_d;
            phase_sh_q  <= phase_sh_d;
            freq_act_q  <= freq_act_d;
            phase_act_q <= phase_act_d;
            pend_q      <= pend_d;
            lfsr_q      <= lfsr_d;
            v0_q        <= v0_d;
            ch0_q       <= ch0_d;
            ph0_q       <= ph0_d;
            dith0_q     <= dith0_d;
            v1_q        <= v1_d;
            ch1_q       <= ch1_d;
            quad1_q     <= quad1_d;
            fine1_q     <= fine1_d;
            quadc1_q    <= quadc1_d;
            finec1_q    <= finec1_d;
            v2_q        <= v2_d;
            ch2_q       <= ch2_d;
            neg2_q      <= neg2_d;
            negc2_q     <= negc2_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_sin_q   <= out_sin_d;
            out_cos_q   <= out_cos_d;
        end
    end

    nco_quarter_rom #(
        .ABITS  (QBITS),
        .DWIDTH (LUT_WIDTH)
    ) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr_a (fine1_q),
        .data_a (rom_sin_raw)
`ifdef NCO_QUAD_OUT_EN
        ,
        .addr_b (finec1_q),
        .data_b (rom_cos_raw)
`endif
    );

`ifdef NCO_QUAD_OUT_EN
    assign out_cos = out_cos_q;
`else
    // Without the quadrature port the cos path has no ROM behind it and folds away
    assign rom_cos_raw = '0;
    logic unused_cos;
    assign unused_cos = ^{out_cos_q, finec1_q};
`endif

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_sin   = out_sin_q;

endmodule

// File: doc/nco_mc_quarter.md
Name: nco_mc_quarter

Overview:
- Time-multiplexed multi-channel numerically controlled oscillator; one phase-accumulator slot per clock, channels served round-robin.
- Quarter-wave sine ROM with quadrant folding, per-channel frequency and phase offset, LFSR phase dither.
- Shadow configuration registers with coherent (sweep-aligned) update.
- Sits between the control/config bus and the DSP mixer datapath; out_ch tags each sample.

Parameters:
- NUM_CH, 4, number of channels (>=2); CH_W = $clog2(NUM_CH).
- ACC_WIDTH, 24, phase accumulator width; full turn = 2^ACC_WIDTH.
- ADDR_WIDTH, 10, full-circle phase index width; ROM depth 2^(ADDR_WIDTH-2).
- LUT_WIDTH, 16, signed output sample width.
- DITHER_WIDTH, 3, dither bits added to phase index; 0 = no dither.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  issue one channel slot per cycle when high
- cfg_we  in  1  shadow register write strobe
- cfg_sel  in  1  0 = frequency step, 1 = phase offset
- cfg_ch  in  CH_W  channel to write
- cfg_data  in  ACC_WIDTH  write data (unsigned, modulo 2^ACC_WIDTH)
- update  in  1  request transfer of all shadows to active registers
- out_valid  out  1  sample valid
- out_ch  out  CH_W  channel of sample
- out_sin  out  LUT_WIDTH  signed sine sample

Behaviour:
- Reset (async assert, sync release): ch_cnt, all accumulators, shadow/active freq and phase, pending flag, pipeline = 0; out_valid=0, out_ch=0, out_sin=0; LFSR = 16'hACE1.
- Slot issue: cycle with en=1 and ch_cnt=k. At that edge: ph <= acc[k]+phase_act[k] (pre-increment value); acc[k] <= acc[k]+freq_act[k] mod 2^ACC_WIDTH; ch_cnt <= (k==NUM_CH-1)?0:k+1.
- en=0: ch_cnt, accumulators and LFSR hold; pipeline keeps draining; out_valid drops 4 edges later.
- Pipeline, latency 4 edges from issue edge to output, fully pipelined, one sample/cycle:
  - E0: phase sum registered.
  - E1: idx = ph[ACC_WIDTH-1 -: ADDR_WIDTH] + dither, mod 2^ADDR_WIDTH (wrap, no saturation); quadrant q = idx[MSB:MSB-1]; fine = lower ADDR_WIDTH-2 bits, mirrored (Q-1-fine) when q is 1 or 3.
  - E2: ROM read; ROM[i] = round(sin(2*pi*(i+0.5)/2^ADDR_WIDTH) * (2^(LUT_WIDTH-1)-1)). Half-step offset makes mirroring exact.
  - E3: out_sin = ROM value, negated for q = 2 or 3; out_ch, out_valid from delayed tags.
- Amplitude never exceeds +-(2^(LUT_WIDTH-1)-1); negation never overflows.
- Dither: 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1, advanced on each issue; dither = low DITHER_WIDTH bits, zero-extended, unsigned.
- Config: cfg_we writes shadow only; never affects the active sweep.
- update sets pending.
- Pending is applied (shadow -> active, pending cleared) at the edge of the last slot of a sweep (en=1, ch_cnt=NUM_CH-1), or at any edge while en=0. Every channel of the next sweep uses the new values.
- update in the same cycle as the apply condition: applied at that edge.
- cfg_we in the same cycle as the apply edge: the transfer uses pre-edge shadow contents; the new write stays in shadow until the next update.
- Repeated update while pending: no extra effect.
- Reset mid-operation: everything returns to reset values immediately; partial pipeline contents are discarded.

Optional Feature:
- NCO_QUAD_OUT_EN defined:
  - Adds port out_cos (out, LUT_WIDTH), sample of phase + quarter turn from the same slot, same latency and tags.
  - Uses a second ROM read port with the same dither value.
- Undefined: port absent, single ROM read.

Decomposition:
- Package nco_pkg:
  - CFG_SEL_FREQ/CFG_SEL_PHASE constants.
  - NCO_LATENCY = 4.
  - LFSR_SEED, LFSR taps.
  - ROM init function (real-valued, elaboration time).
- Sub-module nco_quarter_rom: synchronous 1- or 2-read-port quarter-wave ROM, parametrised by ADDR_WIDTH-2 and LUT_WIDTH.

Test Plan:
- Reset: rst_n low mid-run, no clock edge -> out_valid=0, out_sin=0 immediately; after release first out_valid exactly 4 edges after first issue, out_ch=0.
- Tone: DITHER_WIDTH=0, ch0 freq=2^(ACC_WIDTH-ADDR_WIDTH), update, en=1 -> ch0 samples at indices 0, 255, 256, 512, 768 = ROM[0], +max, +max, -ROM[0], -max (max = ROM[255]). 1024-sample period.
- Offset: ch1 same freq, phase=2^(ACC_WIDTH-2) -> ch1 sample n equals ch0 sample n+256. With NCO_QUAD_OUT_EN, ch0 out_cos equals ch1 out_sin each sweep.
- Coherent update: write ch2 freq while ch_cnt=1 and pulse update -> old step used through slot 3; all channels switch in the same sweep. cfg_we on the apply edge is not applied.
- Stall: en low 10 cycles -> out_valid low from the 4th edge on, accumulators unchanged; after resume, phase continues with no skipped step.
- Wrap: freq=2^ACC_WIDTH-1 -> phase decrements by 1 per sweep, wraps 0 -> max with continuous output; DITHER_WIDTH=3 near index 1023 wraps index modulo 1024.
